// File: rtl/ram_pkg.sv
// Shared types and defaults for the ram_unit data memory.
// RAM_CLEAR_ON_RESET_EN enables the zero-fill sweep in ram_unit.
package ram_pkg;

   localparam int RAM_DATA_WIDTH   = 32;
   localparam int RAM_ADDR_WIDTH   = 9;
   localparam int RAM_DEPTH        = 512;
   localparam int RAM_READ_LATENCY = 1;
   localparam int RAM_CNT_W        = 3;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_RD,
      ST_DONE
   } ram_state_e;

   function automatic int bytes_per_word(input int dw);
      return dw / 8;
   endfunction

   localparam int RAM_BYTES = bytes_per_word(RAM_DATA_WIDTH);

endpackage

// File: rtl/ram_array.sv
// Word storage: byte-masked synchronous write, registered read port
// with synchronous clear.
module ram_array
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = RAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
   parameter int DEPTH      = RAM_DEPTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [ADDR_WIDTH-1:0]   waddr_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic                    re_i,
   input  logic                    rclr_i,
   input  logic [ADDR_WIDTH-1:0]   raddr_i,
   output logic [DATA_WIDTH-1:0]   rdata_o
);

   localparam int NB = bytes_per_word(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NB; i++) begin
         if (we_i && be_i[i]) begin
            mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   // Out-of-range reads return zero instead of touching the array.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= rclr_i ? '0 : mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_unit.sv
// Data memory with Read/Write -> Done handshake and range check.
// Define RAM_CLEAR_ON_RESET_EN to zero-fill the array after reset.
module ram_unit
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH   = RAM_DATA_WIDTH,
   parameter int ADDR_WIDTH   = RAM_ADDR_WIDTH,
   parameter int DEPTH        = RAM_DEPTH,
   parameter int READ_LATENCY = RAM_READ_LATENCY
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    Read,
   input  logic                    Write,
   input  logic [ADDR_WIDTH-1:0]   Address,
   input  logic [DATA_WIDTH-1:0]   Mdatain,
   input  logic [DATA_WIDTH/8-1:0] ByteEn,
   output logic [DATA_WIDTH-1:0]   data_output,
   output logic                    Busy,
   output logic                    Done,
   output logic                    Error
);

   localparam int NB = bytes_per_word(DATA_WIDTH);

   ram_state_e            state_q, state_d;
   logic [RAM_CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  oob_q, oob_d;
   logic                  in_range;
   logic                  rd_fire;
   logic                  we;
   logic [NB-1:0]         we_be;
   logic [ADDR_WIDTH-1:0] we_addr;
   logic [DATA_WIDTH-1:0] we_data;

   assign in_range = {1'b0, Address} < (ADDR_WIDTH+1)'(DEPTH);

`ifdef RAM_CLEAR_ON_RESET_EN
   localparam ram_state_e RST_STATE = ST_INIT;
   logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
   logic                  sweep_last;

   assign sweep_last = (sweep_q == ADDR_WIDTH'(DEPTH - 1));

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sweep_q <= '0;
      end else begin
         sweep_q <= sweep_d;
      end
   end
`else
   localparam ram_state_e RST_STATE = ST_IDLE;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         addr_q  <= '0;
         oob_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         oob_q   <= oob_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      oob_d   = oob_q;
      rd_fire = 1'b0;
      we      = 1'b0;
      we_be   = ByteEn;
      we_addr = Address;
      we_data = Mdatain;
`ifdef RAM_CLEAR_ON_RESET_EN
      sweep_d = sweep_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (Write || Read) begin
               addr_d = Address;
               oob_d  = !in_range;
               if (Write) begin
                  we      = in_range && !Reset;
                  state_d = ST_DONE;
               end else begin
                  cnt_d   = RAM_CNT_W'(READ_LATENCY - 1);
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            if (cnt_q == '0) begin
               rd_fire = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_INIT: begin
`ifdef RAM_CLEAR_ON_RESET_EN
            we      = 1'b1;
            we_be   = '1;
            we_addr = sweep_q;
            we_data = '0;
            sweep_d = sweep_q + 1'b1;
            if (sweep_last) begin
               state_d = ST_IDLE;
            end
`else
            state_d = ST_IDLE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   ram_array #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (DEPTH)
   ) u_array (
      .clk_i  (Clock),
      .rst_i  (Reset),
      .we_i   (we),
      .be_i   (we_be),
      .waddr_i(we_addr),
      .wdata_i(we_data),
      .re_i   (rd_fire),
      .rclr_i (oob_q),
      .raddr_i(addr_q),
      .rdata_o(data_output)
   );

   assign Busy  = (state_q != ST_IDLE);
   assign Done  = (state_q == ST_DONE);
   assign Error = (state_q == ST_DONE) && oob_q;

endmodule

// File: tb/tb_ram_unit.sv
// Directed bench: u0 default build, u1 with DEPTH=300 and READ_LATENCY=3.
module tb_ram_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rd   [2];
   logic        wr   [2];
   logic [8:0]  addr [2];
   logic [31:0] wdat [2];
   logic [3:0]  be   [2];
   logic [31:0] dout [2];
   logic        busy [2];
   logic        done [2];
   logic        err  [2];
   logic [31:0] exp_q [2];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   ram_unit u0 (
      .Clock(clk), .Reset(rst), .Read(rd[0]), .Write(wr[0]),
      .Address(addr[0]), .Mdatain(wdat[0]), .ByteEn(be[0]),
      .data_output(dout[0]), .Busy(busy[0]), .Done(done[0]),
      .Error(err[0])
   );

   ram_unit #(.DEPTH(300), .READ_LATENCY(3)) u1 (
      .Clock(clk), .Reset(rst), .Read(rd[1]), .Write(wr[1]),
      .Address(addr[1]), .Mdatain(wdat[1]), .ByteEn(be[1]),
      .data_output(dout[1]), .Busy(busy[1]), .Done(done[1]),
      .Error(err[1])
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic status(input string tag, input int u, input logic b,
                         input logic d, input logic e);
      chk({tag, "_busy"}, {31'd0, busy[u]}, {31'd0, b});
      chk({tag, "_done"}, {31'd0, done[u]}, {31'd0, d});
      chk({tag, "_err"},  {31'd0, err[u]},  {31'd0, e});
      chk({tag, "_dout"}, dout[u], exp_q[u]);
   endtask

   task automatic do_write(input int u, input logic [8:0] a,
                           input logic [31:0] d, input logic [3:0] b,
                           input logic e);
      @(negedge clk);
      wr[u] = 1'b1; addr[u] = a; wdat[u] = d; be[u] = b;
      @(posedge clk); #1;
      wr[u] = 1'b0;
      status("wr_e0", u, 1'b1, 1'b1, e);
      @(posedge clk); #1;
      status("wr_e1", u, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_read(input int u, input logic [8:0] a, input int lat,
                          input logic [31:0] d, input logic e);
      @(negedge clk);
      rd[u] = 1'b1; addr[u] = a;
      @(posedge clk); #1;
      rd[u] = 1'b0;
      status("rd_e0", u, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k < lat; k++) begin
         @(posedge clk); #1;
         status("rd_wait", u, 1'b1, 1'b0, 1'b0);
      end
      @(posedge clk); #1;
      exp_q[u] = d;
      status("rd_data", u, 1'b1, 1'b1, e);
      @(posedge clk); #1;
      status("rd_idle", u, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int u = 0; u < 2; u++) begin
         rd[u] = 1'b0; wr[u] = 1'b0; addr[u] = '0;
         wdat[u] = '0; be[u] = '0; exp_q[u] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      status("reset0", 0, 1'b0, 1'b0, 1'b0);
      status("reset1", 1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      do_write(0, 9'd5, 32'hDEADBEEF, 4'hF, 1'b0);
      do_read (0, 9'd5, 1, 32'hDEADBEEF, 1'b0);
      do_write(0, 9'd5, 32'h000000AA, 4'h1, 1'b0);
      do_read (0, 9'd5, 1, 32'hDEADBEAA, 1'b0);
      do_write(0, 9'd5, 32'hFFFFFFFF, 4'h0, 1'b0);
      do_read (0, 9'd5, 1, 32'hDEADBEAA, 1'b0);
      do_write(0, 9'd5, 32'h12345678, 4'hA, 1'b0);
      do_read (0, 9'd5, 1, 32'h12AD56AA, 1'b0);
      do_write(0, 9'd511, 32'hCAFEF00D, 4'hF, 1'b0);
      do_read (0, 9'd511, 1, 32'hCAFEF00D, 1'b0);

      // Both strobes high and held through the DONE cycle.
      @(negedge clk);
      wr[0] = 1'b1; rd[0] = 1'b1; addr[0] = 9'd7;
      wdat[0] = 32'h0BADF00D; be[0] = 4'hF;
      @(posedge clk); #1;
      status("wrrd_e0", 0, 1'b1, 1'b1, 1'b0);
      @(posedge clk); #1;
      status("wrrd_e1", 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      wr[0] = 1'b0; rd[0] = 1'b0;
      do_read(0, 9'd7, 1, 32'h0BADF00D, 1'b0);

      do_write(1, 9'd144, 32'h11223344, 4'hF, 1'b0);
      do_read (1, 9'd144, 3, 32'h11223344, 1'b0);
      do_write(1, 9'd299, 32'h55667788, 4'hF, 1'b0);
      do_read (1, 9'd299, 3, 32'h55667788, 1'b0);
      do_write(1, 9'd400, 32'hFFFFFFFF, 4'hF, 1'b1);
      do_write(1, 9'd300, 32'hFFFFFFFF, 4'hF, 1'b1);
      do_read (1, 9'd400, 3, 32'h00000000, 1'b1);
      do_read (1, 9'd144, 3, 32'h11223344, 1'b0);
      do_read (1, 9'd299, 3, 32'h55667788, 1'b0);

      // Reset in the middle of a 3-cycle read on u1.
      @(negedge clk);
      rd[1] = 1'b1; addr[1] = 9'd299;
      @(posedge clk); #1;
      rd[1] = 1'b0;
      status("rst_e0", 1, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      status("rst_e1", 1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      exp_q[0] = '0;
      exp_q[1] = '0;
      status("rst_hit1", 1, 1'b0, 1'b0, 1'b0);
      status("rst_hit0", 0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         status("rst_after", 1, 1'b0, 1'b0, 1'b0);
      end

      do_read(1, 9'd144, 3, 32'h11223344, 1'b0);
      do_read(0, 9'd7, 1, 32'h0BADF00D, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_unit.md
# ram_unit

Parametrised single-port data memory with a request/done handshake for the CPU memory stage. It supersedes the fixed 512 x 32 array with configurable width, depth and read latency, per-byte write enables, out-of-range detection and an optional zero-fill sweep on reset. It sits behind the MAR/MDR path: the control unit raises Read or Write and waits for Done before advancing.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8
- ADDR_WIDTH, 9, address width in bits
- DEPTH, 512, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH
- READ_LATENCY, 1, clock edges from read acceptance to data_output update; 1..8
- Clock  in  1  single clock; all state changes on posedge
- Reset  in  1  synchronous, active-high reset
- Read  in  1  read request strobe
- Write  in  1  write request strobe; wins over Read if both high
- Address  in  ADDR_WIDTH  word address, sampled at acceptance
- Mdatain  in  DATA_WIDTH  write data, sampled at acceptance
- ByteEn  in  DATA_WIDTH/8  per-byte write mask, bit i covers bits [8i+7:8i]; ignored on reads
- data_output  out  DATA_WIDTH  read data; holds its value until the next read completes
- Busy  out  1  high whenever state != IDLE
- Done  out  1  one-cycle completion pulse
- Error  out  1  valid with Done; request addressed >= DEPTH

## Operation
- States: INIT (macro-only), IDLE, RD, DONE.
- Acceptance: at a posedge in IDLE with Read or Write high. Address and Mdatain are latched at this edge. Strobes outside IDLE are ignored; they are not queued.
- Write accept:
  - Each byte with ByteEn[i]=1 is written at the accept edge; other bytes are unchanged.
  - ByteEn=0 is a legal no-op write that still completes with Done.
  - Next state is DONE.
- Read accept: latency counter loads READ_LATENCY-1; next state is RD.
- RD:
  - If the counter is 0, data_output <= mem[addr_q] and the next state is DONE.
  - Otherwise the counter decrements.
- DONE: Done=1 for exactly this cycle, then IDLE unconditionally. No acceptance occurs in DONE.
- Out-of-range (addr >= DEPTH):
  - Write is suppressed.
  - Read loads data_output with 0.
  - Error=1 during the DONE cycle; otherwise Error=0.
- Reset values: data_output=0, Busy=0 (1 while INIT is active), Done=0, Error=0, counter=0.
- Reset in any state aborts the operation. A pending read is dropped and data_output is cleared. A write already committed at its accept edge persists unless the INIT sweep runs.
- Memory contents are not altered by reset unless RAM_CLEAR_ON_RESET_EN is defined. Simulation initialises the array to zero.

## Timing
- Write: accept edge E0, Done high in cycle E0..E1, IDLE after E1. Throughput is 2 cycles per write.
- Read: accept E0, data_output valid after edge E(READ_LATENCY), Done high in the cycle after that edge. Throughput is READ_LATENCY+1 cycles.
- A read accepted at or after a write's DONE cycle returns the new data; there is no hazard window.
- Done and Error are registered; there are no combinational input-to-output paths.

## Configuration
- RAM_CLEAR_ON_RESET_EN defined:
  - Reset enters INIT.
  - A sweep counter writes 0 to words 0..DEPTH-1, one word per cycle.
  - The state is IDLE after DEPTH cycles.
  - Busy=1 throughout and requests are ignored.
  - Reset during INIT restarts the sweep at word 0.
- Not defined: INIT and the sweep counter are absent. Reset goes to IDLE and contents are retained.

## Structure
- Package ram_pkg holds:
  - the state enum (INIT, IDLE, RD, DONE);
  - the default parameter constants;
  - a bytes-per-word localparam helper.
- Sub-module ram_array holds the storage with a synchronous byte-masked write port and a synchronous read port.
- ram_unit holds the FSM, latency counter, range check and sweep logic.

## Test plan
- Write 0xDEADBEEF to address 5 with ByteEn=4'hF, then read 5 -> Done one cycle after the write accept; read gives data_output=0xDEADBEEF with Error=0.
- Write 0x000000AA to address 5 with ByteEn=4'h1 over 0xDEADBEEF -> a read of 5 returns 0xDEADBEAA.
- READ_LATENCY=3, read accepted at E0 -> data_output changes only at E3, Done in the cycle after E3, Busy high E0..E4.
- DEPTH=300, read of address 400 -> data_output=0, Error=1 with Done. A write to 400 is followed by a read of 144 showing that word unchanged.
- Write and Read both high at address 7 -> treated as a write. Strobes held high during Busy are not accepted a second time.
- Reset asserted in RD mid-latency -> next cycle Busy=0, Done=0, data_output=0. With RAM_CLEAR_ON_RESET_EN, Busy stays high for DEPTH cycles and every word then reads 0.
